writeback_scoreboard: RTL
=========================

// Module: writeback_scoreboard
// PURPOSE
//  Writeback stage feeding the 32x32 register file's single write port.
//  - Merges in-order pipeline results with out-of-order long-latency results (div/mem).
//  - Keeps a per-register busy scoreboard so decode can stall on pending destinations.
//  - Drives regfile write signals from flops, 1 cycle after acceptance. The regfile's
//    same-cycle write-read bypass then covers the retire cycle.
// PARAMETERS
//  MAX_PENDING   4   max outstanding long-latency ops (1..15)
//  STARVE_LIMIT  4   consecutive lost arbitration cycles before pipeline is stalled (>=1)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   async active-low reset
//  pipe_valid     in   1   pipeline result valid (ignored while pipe_stall=1)
//  pipe_rd        in   5   pipeline destination
//  pipe_data      in   32  pipeline result
//  pipe_stall     out  1   registered; pipeline must hold its result this cycle
//  issue_valid    in   1   long-latency op issued this cycle
//  issue_rd       in   5   its destination
//  issue_ready    out  1   comb; issue accepted when issue_valid && issue_ready
//  lu_valid       in   1   long-latency result valid
//  lu_rd          in   5   result destination
//  lu_data        in   32  result data
//  lu_ready       out  1   comb; result consumed when lu_valid && lu_ready
//  rs1, rs2       in   5   decode source query
//  rs1_busy       out  1   comb; busy[rs1] (always 0 for x0)
//  rs2_busy       out  1   comb; busy[rs2] (always 0 for x0)
//  reg_write      out  1   registered; to regfile regWrite
//  write_register out  5   registered; to regfile writeRegister
//  write_data     out  32  registered; to regfile writeData
//  sb_error       out  1   sticky protocol-violation flag
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - reg_write, write_register, write_data, pipe_stall, sb_error, starve counter, pending count: 0.
//  - busy[31:1] cleared.
//  - A mid-operation reset drops all pending ops; issue_ready=1 in the first cycle after release.
//  Issue
//  - issue_ready = (pending < MAX_PENDING) && (issue_rd==0 || !busy[issue_rd]).
//  - Busy uses pre-edge state, so an issue to an rd retiring this same cycle is refused.
//  - Accepted issue: pending+1; busy[issue_rd] set if rd!=0.
//  - rd=0 still counts in pending but sets no busy bit.
//  Arbitration, one write per cycle
//  - pipe_stall=0: pipeline wins. lu_ready = !pipe_valid.
//  - pipe_stall=1: pipeline ignored. lu_ready = 1.
//  Retire of an lu handshake
//  - pending-1 and busy[lu_rd] cleared on the same edge that loads the output flops.
//  - Same cycle as issue: pending net unchanged.
//  Output register, on each edge
//  - reg_write <= winner valid && winner rd != 0.
//  - write_register/write_data <= winner rd/data; they hold their previous values when no winner.
//  - x0 writes never reach the regfile.
//  - Latency accept -> reg_write is exactly 1 cycle.
//  Starvation
//  - Counter increments each cycle lu_valid && !lu_ready; clears on lu handshake or !lu_valid.
//  - When counter == STARVE_LIMIT-1 and lu still loses, pipe_stall <= 1 for exactly one cycle;
//    that cycle lu wins and the counter clears.
//  - Worst-case lu wait: STARVE_LIMIT+1 cycles.
//  sb_error (set, never cleared except by reset)
//  - lu handshake with lu_rd!=0 and !busy[lu_rd].
//  - lu handshake while pending==0.
//  - pipe write (accepted) to rd!=0 with busy[rd]=1 (WAW).
// TESTING
//  1. Reset, then pipe_valid rd=5 data=0xA5A5A5A5 -> next cycle reg_write=1, write_register=5,
//     write_data=0xA5A5A5A5.
//  2. Issue rd=7 -> rs1=7 gives rs1_busy=1. lu result rd=7 0x1234 with pipe idle -> busy clears
//     and reg_write for x7 on the same edge. pending returns to 0.
//  3. Issue rd=0,1,2,3 (MAX_PENDING=4) -> issue_ready=0 for a 5th issue. Retire one -> issue_ready=1.
//  4. pipe_valid held high, lu_valid held rd=3 -> lu_ready=0 for 4 cycles, then pipe_stall=1
//     for 1 cycle, x3 written, pipe result written the following cycle.
//  5. lu result rd=9 with busy[9]=0 -> sb_error=1 and remains 1. Assert rst_n=0 mid-stream ->
//     all outputs 0 immediately.
//  6. pipe write rd=0 -> reg_write stays 0. Issue rd=4 in the same cycle x4 retires -> refused.

Source files
------------

// File: rtl/writeback_scoreboard.sv
// Writeback stage for the 32x32 register file's single write port.
// Merges in-order pipeline results with out-of-order long-latency results,
// keeps a per-register busy scoreboard for decode stalls, and drives the
// regfile write port from flops one cycle after a result is accepted.
module writeback_scoreboard #(
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_valid,
    input  logic [4:0]        pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    output logic              issue_ready,
    input  logic              lu_valid,
    input  logic [4:0]        lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              reg_write,
    output logic [4:0]        write_register,
    output logic [DATA_W-1:0] write_data,
    output logic              sb_error
);

    localparam int PW = 4;
    localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    logic [31:0]   busy;
    logic [PW-1:0] pending;
    logic [CW-1:0] starve_cnt;

    logic              pipe_win_p0;
    logic              lu_hs_p0;
    logic              issue_hs_p0;
    logic              lu_lose_p0;
    logic              win_vld_p0;
    logic [4:0]        win_rd_p0;
    logic [DATA_W-1:0] win_data_p0;
    logic [31:0]       busy_nxt;
    logic              err_nxt;

    // x0 is never tracked, so it always reads as free.
    function automatic logic busy_of(input logic [31:0] b, input logic [4:0] rd);
        return (rd != 5'd0) && b[rd];
    endfunction

    // Pending count update, clamped so a spurious retire cannot wrap below zero.
    function automatic logic [PW-1:0] pend_update(input logic [PW-1:0] p,
                                                  input logic inc, input logic dec);
        logic [PW-1:0] r;
        r = p;
        if (inc && !dec && (p != {PW{1'b1}}))
            r = p + PW'(1);
        else if (dec && !inc && (p != '0))
            r = p - PW'(1);
        return r;
    endfunction

    // Busy checks use pre-edge state: an rd retiring this cycle still refuses a new issue.
    assign issue_ready = (pending < PW'(MAX_PENDING)) && !busy_of(busy, issue_rd);
    assign lu_ready    = pipe_stall | ~pipe_valid;
    assign rs1_busy    = busy_of(busy, rs1);
    assign rs2_busy    = busy_of(busy, rs2);

    assign pipe_win_p0 = pipe_valid && !pipe_stall;
    assign lu_hs_p0    = lu_valid && lu_ready;
    assign issue_hs_p0 = issue_valid && issue_ready;
    assign lu_lose_p0  = lu_valid && !lu_ready;
    assign win_vld_p0  = pipe_win_p0 || lu_hs_p0;
    assign win_rd_p0   = pipe_win_p0 ? pipe_rd   : lu_rd;
    assign win_data_p0 = pipe_win_p0 ? pipe_data : lu_data;

    // Next busy vector: retire clears first, then a new issue may set.
    always_comb begin
        busy_nxt = busy;
        if (lu_hs_p0 && (lu_rd != 5'd0))
            busy_nxt[lu_rd] = 1'b0;
        if (issue_hs_p0 && (issue_rd != 5'd0))
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Protocol violations: retire of an untracked rd, retire with nothing pending, WAW pipe write.
    always_comb begin
        err_nxt = 1'b0;
        if (lu_hs_p0 && (((lu_rd != 5'd0) && !busy[lu_rd]) || (pending == '0)))
            err_nxt = 1'b1;
        if (pipe_win_p0 && busy_of(busy, pipe_rd))
            err_nxt = 1'b1;
    end

    // Control state: scoreboard, pending count, starvation counter, stall and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            pending    <= '0;
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
            sb_error   <= 1'b0;
            reg_write  <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            pending   <= pend_update(pending, issue_hs_p0, lu_hs_p0);
            sb_error  <= sb_error | err_nxt;
            reg_write <= win_vld_p0 && (win_rd_p0 != 5'd0);
            if (lu_lose_p0) begin
                if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
                    pipe_stall <= 1'b1;
                end else begin
                    starve_cnt <= starve_cnt + CW'(1);
                    pipe_stall <= 1'b0;
                end
            end else begin
                starve_cnt <= '0;
                pipe_stall <= 1'b0;
            end
        end
    end

    // Stage p0 -> p1: winner rd/data loaded into the regfile write flops, held when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_register <= '0;
            write_data     <= '0;
        end else if (win_vld_p0) begin
            write_register <= win_rd_p0;
            write_data     <= win_data_p0;
        end
    end

endmodule
